// File: rtl/nes_ram_host_bridge_if.sv
// Host PIO / NES memory bus bundle for nes_ram_host_bridge.
// master = software PIO + NES core side, slave = the bridge.
interface nes_ram_host_bridge_if;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_req;
  logic        host_wr;
  logic [7:0]  dout;
  logic        host_done;
  logic        host_busy;
  logic        host_err;
  logic        mem_grant;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  modport master (
    output host_addr, host_wdata, host_req, host_wr, mem_grant, mem_rdata,
    input  dout, host_done, host_busy, host_err, mem_addr, mem_wdata, mem_re, mem_we
  );

  modport slave (
    input  host_addr, host_wdata, host_req, host_wr, mem_grant, mem_rdata,
    output dout, host_done, host_busy, host_err, mem_addr, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/nes_ram_host_bridge.sv
// Nios PIO to NES RAM single-byte access bridge (four-phase host handshake).
// Optional grant timeout compiled in with NES_RAM_BRIDGE_TIMEOUT_EN.
module nes_ram_host_bridge #(
  parameter int READ_LATENCY   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nes_ram_host_bridge_if.slave  bus
);

  if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
    $error("READ_LATENCY must be 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..65535");
  end

  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, WAIT_GRANT, STROBE, LATENCY, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        wr_flag;
  logic        re, we;
  logic        done;
  logic [7:0]  dout_reg;
  logic [3:0]  lat_cnt;
  logic        accept, fire, finish_rd, abort, timeout_hit;

`ifdef NES_RAM_BRIDGE_TIMEOUT_EN
  logic [15:0] dwell;
  logic        err;

  assign timeout_hit = (dwell == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell <= '0;
      err   <= 1'b0;
    end else begin
      if (accept)                  dwell <= '0;
      else if (state == WAIT_GRANT) dwell <= dwell + 16'd1;
      if (accept)     err <= 1'b0;
      else if (abort) err <= 1'b1;
    end
  end

  assign bus.host_err = err;
`else
  assign timeout_hit  = 1'b0;
  assign bus.host_err = 1'b0;
`endif

  // Grant wins over timeout when both land on the same edge.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    fire       = 1'b0;
    finish_rd  = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE:
        if (bus.host_req && !done) begin
          accept     = 1'b1;
          state_next = WAIT_GRANT;
        end
      WAIT_GRANT:
        if (bus.mem_grant) begin
          fire       = 1'b1;
          state_next = STROBE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      STROBE:
        state_next = wr_flag ? DONE : LATENCY;
      LATENCY:
        if (lat_cnt == 4'd0) begin
          finish_rd  = 1'b1;
          state_next = DONE;
        end
      DONE:
        if (!bus.host_req) state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr     <= '0;
      wdata    <= '0;
      wr_flag  <= 1'b0;
      re       <= 1'b0;
      we       <= 1'b0;
      done     <= 1'b0;
      dout_reg <= '0;
      lat_cnt  <= '0;
    end else begin
      state <= state_next;
      re    <= fire & ~wr_flag;
      we    <= fire & wr_flag;
      done  <= (state_next == DONE);
      if (accept) begin
        addr    <= bus.host_addr;
        wdata   <= bus.host_wdata;
        wr_flag <= bus.host_wr;
      end
      if (state == STROBE)
        lat_cnt <= LAT_INIT;
      else if (state == LATENCY && lat_cnt != 4'd0)
        lat_cnt <= lat_cnt - 4'd1;
      if (finish_rd)  dout_reg <= bus.mem_rdata;
      else if (abort) dout_reg <= 8'hFF;
    end
  end

  assign bus.dout      = dout_reg;
  assign bus.host_done = done;
  assign bus.host_busy = (state != IDLE);
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.mem_re    = re;
  assign bus.mem_we    = we;

endmodule

// File: tb/tb_nes_ram_host_bridge.sv
// Directed bench for nes_ram_host_bridge with a fixed-latency NES RAM model.
module tb_nes_ram_host_bridge;
  localparam int RL = 2;
`ifdef NES_RAM_BRIDGE_TIMEOUT_EN
  localparam int HOLD = 5;
`else
  localparam int HOLD = 50;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  nes_ram_host_bridge_if bus ();

  nes_ram_host_bridge #(.READ_LATENCY(RL), .TIMEOUT_CYCLES(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // RAM model: returns mem_val for the edge RL cycles after the strobe edge.
  logic [7:0]  mem_val;
  int          lat = 0;
  int          re_cnt = 0;
  int          we_cnt = 0;
  logic [7:0]  we_data = 8'h00;

  always @(posedge clk) begin
    bus.mem_rdata <= 8'h5A;
    if (lat == 1) bus.mem_rdata <= mem_val;
    if (lat != 0) lat <= lat - 1;
    if (bus.mem_re) begin
      re_cnt <= re_cnt + 1;
      lat    <= RL - 1;
    end
    if (bus.mem_we) begin
      we_cnt  <= we_cnt + 1;
      we_data <= bus.mem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.host_req   = 1'b0;
    bus.host_wr    = 1'b0;
    bus.mem_grant  = 1'b1;
    mem_val        = 8'h00;
    step();
    step();
    checks++;
    if ({bus.dout, bus.host_done, bus.host_busy, bus.host_err, bus.mem_re, bus.mem_we} !== 13'h0) begin
      failures++;
      $display("FAIL reset_status: got dout=%h done=%b busy=%b err=%b re=%b we=%b, want all 0",
               bus.dout, bus.host_done, bus.host_busy, bus.host_err, bus.mem_re, bus.mem_we);
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== 24'h0) begin
      failures++;
      $display("FAIL reset_bus: got addr=%h wdata=%h, want 0", bus.mem_addr, bus.mem_wdata);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_read();
    int re0;
    re0 = re_cnt;
    mem_val       = 8'hA5;
    bus.host_addr = 16'h0123;
    bus.host_wr   = 1'b0;
    bus.host_req  = 1'b1;
    step(); // edge 0
    checks++;
    if (bus.host_busy !== 1'b1) begin
      failures++; $display("FAIL read_busy: got %b want 1", bus.host_busy);
    end
    step(); // edge 1
    checks++;
    if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0123) begin
      failures++;
      $display("FAIL read_strobe: got re=%b we=%b addr=%h want re=1 we=0 addr=0123", bus.mem_re, bus.mem_we, bus.mem_addr);
    end
    step(); // edge 2
    checks++;
    if (bus.mem_re !== 1'b0) begin
      failures++; $display("FAIL read_strobe_width: got re=%b want 0", bus.mem_re);
    end
    step(); // edge 3
    checks++;
    if (bus.host_done !== 1'b0) begin
      failures++; $display("FAIL read_early_done: got %b want 0", bus.host_done);
    end
    step(); // edge 4
    checks++;
    if (bus.dout !== 8'hA5 || bus.host_done !== 1'b1) begin
      failures++; $display("FAIL read_data: got dout=%h done=%b want A5 1", bus.dout, bus.host_done);
    end
    checks++;
    if (re_cnt - re0 !== 1) begin
      failures++; $display("FAIL read_re_count: got %0d want 1", re_cnt - re0);
    end
    bus.host_req = 1'b0;
    step();
    checks++;
    if (bus.host_done !== 1'b0 || bus.host_busy !== 1'b0) begin
      failures++; $display("FAIL read_release: got done=%b busy=%b want 0 0", bus.host_done, bus.host_busy);
    end
  endtask

  task automatic test_write();
    int re0, we0;
    re0 = re_cnt;
    we0 = we_cnt;
    bus.host_addr  = 16'h07FF;
    bus.host_wdata = 8'h3C;
    bus.host_wr    = 1'b1;
    bus.host_req   = 1'b1;
    step(); // edge 0
    step(); // edge 1
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_addr !== 16'h07FF || bus.mem_wdata !== 8'h3C) begin
      failures++;
      $display("FAIL write_strobe: got we=%b re=%b addr=%h wdata=%h want 1 0 07FF 3C",
               bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata);
    end
    step(); // edge 2
    step(); // edge 3
    checks++;
    if (bus.host_done !== 1'b1 || bus.dout !== 8'hA5) begin
      failures++; $display("FAIL write_done: got done=%b dout=%h want 1 A5", bus.host_done, bus.dout);
    end
    checks++;
    if (we_cnt - we0 !== 1 || re_cnt != re0 || we_data !== 8'h3C) begin
      failures++;
      $display("FAIL write_pulses: got we=%0d re=%0d data=%h want 1 0 3C", we_cnt - we0, re_cnt - re0, we_data);
    end
    bus.host_req = 1'b0;
    bus.host_wr  = 1'b0;
    step();
  endtask

  task automatic test_grant_stall();
    int bad;
    bool_done: begin end
    bad = 0;
    mem_val        = 8'h11;
    bus.mem_grant  = 1'b0;
    bus.host_addr  = 16'h0200;
    bus.host_wr    = 1'b0;
    bus.host_req   = 1'b1;
    step(); // edge 0
    bus.host_addr  = 16'hFFFF;
    bus.host_wr    = 1'b1;
    for (int i = 0; i < HOLD; i++) begin
      step();
      if (bus.host_busy !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.host_err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
    end
    bus.mem_grant = 1'b1;
    step();
    checks++;
    if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0200) begin
      failures++;
      $display("FAIL stall_strobe: got re=%b we=%b addr=%h want 1 0 0200", bus.mem_re, bus.mem_we, bus.mem_addr);
    end
    for (int i = 0; i < 10 && bus.host_done !== 1'b1; i++) step();
    checks++;
    if (bus.host_done !== 1'b1 || bus.dout !== 8'h11) begin
      failures++; $display("FAIL stall_data: got done=%b dout=%h want 1 11", bus.host_done, bus.dout);
    end
    bus.host_req = 1'b0;
    bus.host_wr  = 1'b0;
    step();
  endtask

  task automatic test_req_drop();
    mem_val       = 8'hC3;
    bus.host_addr = 16'h0042;
    bus.host_req  = 1'b1;
    step(); // edge 0
    step(); // edge 1
    step(); // edge 2, now in LATENCY
    bus.host_req = 1'b0;
    step(); // edge 3
    checks++;
    if (bus.host_done !== 1'b0) begin
      failures++; $display("FAIL drop_early: got done=%b want 0", bus.host_done);
    end
    step(); // edge 4
    checks++;
    if (bus.host_done !== 1'b1 || bus.dout !== 8'hC3) begin
      failures++; $display("FAIL drop_complete: got done=%b dout=%h want 1 C3", bus.host_done, bus.dout);
    end
    step(); // edge 5
    checks++;
    if (bus.host_done !== 1'b0 || bus.host_busy !== 1'b0) begin
      failures++; $display("FAIL drop_pulse: got done=%b busy=%b want 0 0", bus.host_done, bus.host_busy);
    end
  endtask

`ifdef NES_RAM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int re0;
    re0 = re_cnt;
    bus.mem_grant = 1'b0;
    bus.host_addr = 16'h0300;
    bus.host_req  = 1'b1;
    for (int i = 0; i < 20 && bus.host_done !== 1'b1; i++) step();
    checks++;
    if (bus.host_done !== 1'b1 || bus.host_err !== 1'b1 || bus.dout !== 8'hFF || re_cnt != re0) begin
      failures++;
      $display("FAIL timeout_abort: got done=%b err=%b dout=%h strobes=%0d want 1 1 FF 0",
               bus.host_done, bus.host_err, bus.dout, re_cnt - re0);
    end
    bus.host_req = 1'b0;
    step();
    mem_val       = 8'h77;
    bus.mem_grant = 1'b1;
    bus.host_req  = 1'b1;
    step();
    checks++;
    if (bus.host_err !== 1'b0) begin
      failures++; $display("FAIL timeout_err_clear: got %b want 0", bus.host_err);
    end
    for (int i = 0; i < 10 && bus.host_done !== 1'b1; i++) step();
    checks++;
    if (bus.dout !== 8'h77) begin
      failures++; $display("FAIL timeout_recover: got dout=%h want 77", bus.dout);
    end
    bus.host_req = 1'b0;
    step();
  endtask
`endif

  task automatic test_reset_mid();
    mem_val       = 8'h99;
    bus.host_addr = 16'h0456;
    bus.host_req  = 1'b1;
    step();
    step();
    step(); // in LATENCY
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.dout, bus.host_done, bus.host_busy, bus.host_err, bus.mem_re, bus.mem_we,
         bus.mem_addr, bus.mem_wdata} !== 37'h0) begin
      failures++;
      $display("FAIL reset_mid: got dout=%h done=%b busy=%b err=%b re=%b we=%b addr=%h wdata=%h want all 0",
               bus.dout, bus.host_done, bus.host_busy, bus.host_err, bus.mem_re, bus.mem_we,
               bus.mem_addr, bus.mem_wdata);
    end
    bus.host_req = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_grant_stall();
    test_req_drop();
`ifdef NES_RAM_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
